lcd_refresh_sched: RTL and testbench

//  Sequences the HD44780-style 16x2 character LCD: power-up wait, 4-command init, then full
//  two-line rewrites from two 128-bit line buffers (16 ASCII chars each, char 0 = bits[127:120]).

---
 rtl/lcd_refresh_sched.sv | 187 ++++++++++++++++++
 tb/tb_lcd_refresh_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_sched.sv
// HD44780-style 16x2 LCD sequencer: power-up wait, 4-command init, then full two-row rewrites
// from snapshotted line buffers whenever a rewrite is requested or the text has changed.
module lcd_refresh_sched #(
    parameter int PWRUP_CYC    = 20000,
    parameter int E_HIGH_CYC   = 2,
    parameter int CMD_WAIT_CYC = 50,
    parameter int CLR_WAIT_CYC = 2000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] line0,
    input  logic [127:0] line1,
    input  logic         upd_req,
    output logic         rs,
    output logic         e,
    output logic [7:0]   data,
    output logic         busy,
    output logic         init_done,
    output logic         upd_ack,
    output logic [2:0]   dbg_state
);

    localparam int LAST_CMD_I = E_HIGH_CYC + CMD_WAIT_CYC;
    localparam int LAST_CLR_I = E_HIGH_CYC + CLR_WAIT_CYC;
    localparam int MAX_A      = (LAST_CLR_I > LAST_CMD_I) ? LAST_CLR_I : LAST_CMD_I;
    localparam int MAX_C      = (PWRUP_CYC > MAX_A) ? PWRUP_CYC : MAX_A;
    localparam int CW         = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] LAST_CMD   = CW'(LAST_CMD_I);
    localparam logic [CW-1:0] LAST_CLR   = CW'(LAST_CLR_I);
    localparam logic [CW-1:0] E_LAST     = CW'(E_HIGH_CYC);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_ADDR0, S_CHR0, S_ADDR1, S_CHR1, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     idx_q, idx_d;
    logic           pending_q, pending_d;
    logic [127:0]   snap0_q, snap0_d, snap1_q, snap1_d;
    logic           init_done_q, init_done_d;
    logic           rs_q, rs_d, e_q, e_d;
    logic [7:0]     data_q, data_d;
    logic           is_clr, wr_last;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Char k of a line sits at bits [127-8k -: 8], i.e. a right shift by 8*(15-k).
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] k);
        char_at = 8'(line >> {~k, 3'b000});
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        snap0_d     = snap0_q;
        snap1_d     = snap1_q;
        init_done_d = init_done_q;
        is_clr      = (state_q == S_INIT) && (idx_q == 4'd3);
        wr_last     = (cnt_q == (is_clr ? LAST_CLR : LAST_CMD));

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (pending_q) begin
                    snap0_d   = line0;
                    snap1_d   = line1;
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    state_d   = S_ADDR0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // Every remaining state is one byte-write primitive per char/command.
                if (!wr_last) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        S_INIT: begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd3) begin
                                idx_d       = '0;
                                state_d     = S_IDLE;
                                init_done_d = 1'b1;
                                pending_d   = 1'b1;
                            end
                        end
                        S_ADDR0: begin
                            idx_d   = '0;
                            state_d = S_CHR0;
                        end
                        S_CHR0: begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd15) state_d = S_ADDR1;
                        end
                        S_ADDR1: begin
                            idx_d   = '0;
                            state_d = S_CHR1;
                        end
                        default: begin
                            idx_d = idx_q + 4'd1;
                            if (idx_q == 4'd15) state_d = S_DONE;
                        end
                    endcase
                end
            end
        endcase

        // Compared against the post-latch snapshot so the latch cycle itself never re-arms.
        if (init_done_q && (upd_req || ({line0, line1} != {snap0_d, snap1_d})))
            pending_d = 1'b1;
    end

    // Pin values are registered from next-state so the LCD never sees decode glitches.
    always_comb begin
        rs_d   = 1'b0;
        e_d    = 1'b0;
        data_d = 8'h00;
        case (state_d)
            S_INIT:  data_d = init_cmd(idx_d[1:0]);
            S_ADDR0: data_d = 8'h80;
            S_CHR0:  begin rs_d = 1'b1; data_d = char_at(snap0_d, idx_d); end
            S_ADDR1: data_d = 8'hC0;
            S_CHR1:  begin rs_d = 1'b1; data_d = char_at(snap1_d, idx_d); end
            default: data_d = 8'h00;
        endcase
        if (state_d inside {S_INIT, S_ADDR0, S_CHR0, S_ADDR1, S_CHR1})
            e_d = (cnt_d != '0) && (cnt_d <= E_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            snap0_q     <= '0;
            snap1_q     <= '0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            e_q         <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            snap0_q     <= snap0_d;
            snap1_q     <= snap1_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            e_q         <= e_d;
            data_q      <= data_d;
        end
    end

    assign rs        = rs_q;
    assign e         = e_q;
    assign data      = data_q;
    assign busy      = (state_q != S_IDLE);
    assign init_done = init_done_q;
    assign upd_ack   = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_refresh_sched.sv
// Directed bench for lcd_refresh_sched with short timing parameters.
module tb_lcd_refresh_sched;

    localparam int PW = 20;
    localparam int EH = 2;
    localparam int CWAIT = 4;
    localparam int CL = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] line0, line1;
    logic         upd_req;
    logic         rs, e, busy, init_done, upd_ack;
    logic [7:0]   data;
    logic [2:0]   dbg_state;

    logic [8:0]   exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           ack_cnt = 0;

    lcd_refresh_sched #(
        .PWRUP_CYC(PW), .E_HIGH_CYC(EH), .CMD_WAIT_CYC(CWAIT), .CLR_WAIT_CYC(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line0(line0), .line1(line1), .upd_req(upd_req),
        .rs(rs), .e(e), .data(data), .busy(busy), .init_done(init_done),
        .upd_ack(upd_ack), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    always @(posedge clk) if (upd_ack === 1'b1) ack_cnt = ack_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for e to rise, captures rs/data, returns at the first sample with e low again.
    task automatic get_byte(output logic b_rs, output logic [7:0] b_data, output int hi_len);
        int n;
        n = 0;
        hi_len = 0;
        b_rs = 1'b0;
        b_data = 8'h00;
        while (e !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (e !== 1'b1) begin
            check("byte_timeout", 32'd0, 32'd1);
        end else begin
            b_rs = rs;
            b_data = data;
            while (e === 1'b1 && hi_len < 100) begin
                hi_len++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_bytes(input int cnt, input string tag);
        logic       b_rs;
        logic [7:0] b_data;
        int         hi;
        logic [8:0] exp;
        for (int i = 0; i < cnt; i++) begin
            get_byte(b_rs, b_data, hi);
            exp = exp_q.pop_front();
            check({tag, "_byte"}, {23'd0, b_rs, b_data}, {23'd0, exp});
            check({tag, "_ehigh"}, hi, EH);
        end
    endtask

    task automatic push_rewrite(input logic [127:0] a, input logic [127:0] b);
        exp_q.push_back({1'b0, 8'h80});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, a[127-8*k -: 8]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, b[127-8*k -: 8]});
    endtask

    // Returns the cycle stamp of the ack sample and leaves the caller one cycle later.
    task automatic wait_ack(input string tag, input logic drop_req, output int t_ack);
        int n;
        n = 0;
        while (upd_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_ack = cyc;
        check({tag, "_ack"}, {31'd0, upd_ack}, 32'd1);
        check({tag, "_ack_delay"}, n, CWAIT);
        if (drop_req) upd_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_oneshot"}, {31'd0, upd_ack}, 32'd0);
    endtask

    task automatic quiet_check(input int cycles, input string tag);
        int e_cnt, b_cnt;
        e_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (e !== 1'b0) e_cnt++;
            if (busy !== 1'b0) b_cnt++;
        end
        check({tag, "_e_pulses"}, e_cnt, 0);
        check({tag, "_busy"}, b_cnt, 0);
    endtask

    // Called right after rst_n is released at a falling edge.
    task automatic run_init(input string tag);
        int n, t0, t_ack;
        n = 0;
        do begin
            @(negedge clk);
            if (e === 1'b1) break;
            n++;
        end while (n < 100);
        check({tag, "_pwrup_len"}, n, PW);
        check({tag, "_init_done_low"}, {31'd0, init_done}, 32'd0);
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        check_bytes(4, {tag, "_init"});
        n = 0;
        while (init_done !== 1'b1 && n < 50) begin
            if (e !== 1'b0) n = 100;
            n++;
            @(negedge clk);
        end
        check({tag, "_clr_wait"}, n, CL);
        t0 = cyc;
        push_rewrite(line0, line1);
        check_bytes(34, {tag, "_first"});
        wait_ack({tag, "_first"}, 1'b0, t_ack);
        check({tag, "_rewrite_cycles"}, t_ack - t0, 239);
    endtask

    initial begin
        int a0, t_ack, n;
        logic [127:0] old1;
        upd_req = 1'b0;
        line0 = "DOOR LOCKED     ";
        line1 = "ENTER PASSWORD  ";
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rs", {31'd0, rs}, 32'd0);
        check("rst_e", {31'd0, e}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_upd_ack", {31'd0, upd_ack}, 32'd0);

        rst_n = 1'b1;
        run_init("boot");

        a0 = ack_cnt;
        quiet_check(1000, "idle");
        check("idle_no_ack", ack_cnt - a0, 0);

        // Text change mid-rewrite: old text completes, then exactly one rewrite with new text.
        a0 = ack_cnt;
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        old1 = line1;
        push_rewrite(line0, old1);
        check_bytes(7, "chg_a");
        line1 = "NEW CODE 1234   ";
        check_bytes(27, "chg_b");
        wait_ack("chg_old", 1'b0, t_ack);
        push_rewrite(line0, line1);
        check_bytes(34, "chg_new");
        wait_ack("chg_new", 1'b0, t_ack);
        quiet_check(100, "chg_quiet");
        check("chg_ack_count", ack_cnt - a0, 2);

        // Held request: back-to-back rewrites separated by a single idle cycle.
        a0 = ack_cnt;
        upd_req = 1'b1;
        push_rewrite(line0, line1);
        check_bytes(34, "req1");
        wait_ack("req1", 1'b1, t_ack);
        check("req_gap_idle", {31'd0, busy}, 32'd0);
        n = 0;
        while (e !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) n = 50;
        end
        check("req_gap_len", n, 2);
        push_rewrite(line0, line1);
        check_bytes(34, "req2");
        wait_ack("req2", 1'b0, t_ack);
        quiet_check(100, "req_quiet");
        check("req_ack_count", ack_cnt - a0, 2);

        // Reset asserted while e is high on a character byte.
        upd_req = 1'b1;
        @(negedge clk);
        upd_req = 1'b0;
        n = 0;
        while (!(e === 1'b1 && rs === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midchar_reached", {31'd0, e & rs}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_e", {31'd0, e}, 32'd0);
        check("async_rs", {31'd0, rs}, 32'd0);
        check("async_data", {24'd0, data}, 32'd0);
        check("async_init_done", {31'd0, init_done}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_init("reboot");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
